program_mem: RTL and testbench
==============================

PROGRAM_MEM -- requirements
Module: program_mem

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning the address width; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter INST_W, default 16, meaning the instruction word width.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port fetch_req, input, 1 bit, a fetch request.
REQ-006 SHALL have port fetch_addr, input, ADDR_W bits, the fetch address.
REQ-007 SHALL have port fetch_ready, output, 1 bit: high when a fetch can be accepted.
REQ-008 SHALL have port instruction, output, INST_W bits, the registered fetch data.
REQ-009 SHALL have port fetch_valid, output, 1 bit: instruction holds fresh data.
REQ-010 SHALL have port load_start, input, 1 bit, a pulse that begins a program load.
REQ-011 SHALL have port load_valid, input, 1 bit, meaning load_data is presented.
REQ-012 SHALL have port load_data, input, INST_W bits, the word to write.
REQ-013 SHALL have port load_last, input, 1 bit, marking the final load word.
REQ-014 SHALL have port load_ready, output, 1 bit: a load word can be accepted.
REQ-015 SHALL have port load_done, output, 1 bit, a one-cycle pulse when a load completes.

Function
REQ-016 SHALL implement a state machine with states IDLE, LOAD and DONE.
REQ-017 IDLE SHALL hold fetch_ready=1 and load_ready=0.
REQ-018 In IDLE, fetch_req=1 SHALL set instruction=mem[fetch_addr] and fetch_valid=1 on the next edge (1-cycle latency).
REQ-019 In IDLE with no fetch, fetch_valid SHALL be 0 and instruction SHALL hold its last value.
REQ-020 In IDLE, load_start=1 SHALL clear the write pointer wptr to 0 and move to LOAD.
REQ-021 If load_start and fetch_req are both high in IDLE, load_start SHALL take priority and the fetch SHALL be dropped (fetch_valid=0).
REQ-022 LOAD SHALL hold fetch_ready=0 and load_ready=1; fetch_req SHALL be ignored and fetch_valid SHALL be 0.
REQ-023 In LOAD, load_valid=1 SHALL write mem[wptr]=load_data and increment wptr by 1.
REQ-024 LOAD SHALL move to DONE after accepting a word with load_last=1 or a word at wptr=2**ADDR_W-1; wptr SHALL NOT wrap to 0.
REQ-025 load_start in LOAD SHALL be ignored.
REQ-026 DONE SHALL last one cycle with load_done=1, fetch_ready=0 and load_ready=0, then return to IDLE.
REQ-027 Words not written during a load SHALL retain their previous contents.
REQ-028 A fetch issued on the first IDLE cycle after DONE SHALL return newly loaded data.

Reset
REQ-029 Reset SHALL force state=IDLE, wptr=0, instruction=0, fetch_valid=0 and load_done=0; fetch_ready=1 and load_ready=0 follow from IDLE.
REQ-030 Reset during LOAD SHALL abandon the load without a load_done pulse; words already written SHALL persist.
REQ-031 Reset SHALL NOT clear memory contents.
REQ-032 Memory contents at power-up SHALL be undefined; the bench SHALL load before fetching.

Configuration
REQ-033 When macro PROG_MEM_PARITY_EN is defined, each word SHALL store an extra even-parity bit computed from load_data on write.
REQ-034 When PROG_MEM_PARITY_EN is defined, there SHALL be an output parity_err (1 bit), valid alongside fetch_valid, set to 1 on parity mismatch; reset value is 0.
REQ-035 When PROG_MEM_PARITY_EN is undefined, there SHALL be no parity storage and no parity_err port.

Verification
REQ-036 Reset, load 0x1E07, 0xFE00, 0xBE01, 0xCA00 with the last word flagged, then fetch addresses 0 to 3 -> load_done pulses once; instruction equals each word one cycle after its fetch_req.
REQ-037 Load 16 words (0x0000 to 0x000F) without load_last -> DONE after the 16th word; fetch 15 returns 0x000F; wptr does not wrap.
REQ-038 Assert fetch_req during LOAD -> fetch_valid stays 0 and fetch_ready stays 0 throughout.
REQ-039 Assert load_start and fetch_req in the same IDLE cycle -> state is LOAD and fetch_valid=0 on the next cycle.
REQ-040 Assert reset after 2 of 4 load words -> no load_done pulse; state is IDLE; fetch 1 returns the second word.
REQ-041 With PROG_MEM_PARITY_EN defined, load 0x0001, force a flip of the stored bit 0, then fetch -> parity_err=1 with fetch_valid=1.

Source files
------------

// File: rtl/program_mem.sv
// Program memory: a fetch port plus a streaming loader (IDLE -> LOAD -> DONE).
// Define PROG_MEM_PARITY_EN to store an even-parity bit per word and report parity_err on fetch.
module program_mem #(
  parameter int ADDR_W = 4,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic [INST_W-1:0] instruction,
  output logic              fetch_valid,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [INST_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
`ifdef PROG_MEM_PARITY_EN
  output logic              load_done,
  output logic              parity_err
`else
  output logic              load_done
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef PROG_MEM_PARITY_EN
  localparam int MEM_W = INST_W + 1;
`else
  localparam int MEM_W = INST_W;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [MEM_W-1:0]  mem [DEPTH];
  logic [MEM_W-1:0]  wr_word, rd_word;
  logic              fetch_accept, wr_en, wptr_at_end;

  assign wptr_at_end = (wptr_q == {ADDR_W{1'b1}});
  assign rd_word     = mem[fetch_addr];

`ifdef PROG_MEM_PARITY_EN
  assign wr_word = {^load_data, load_data};
`else
  assign wr_word = load_data;
`endif

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    fetch_ready  = 1'b0;
    load_ready   = 1'b0;
    load_done    = 1'b0;
    fetch_accept = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      IDLE: begin
        fetch_ready = 1'b1;
        // A load request wins over a same-cycle fetch; that fetch is dropped.
        if (load_start) begin
          state_d = LOAD;
          wptr_d  = '0;
        end else begin
          fetch_accept = fetch_req;
        end
      end
      LOAD: begin
        load_ready = 1'b1;
        if (load_valid) begin
          wr_en = 1'b1;
          if (load_last || wptr_at_end) state_d = DONE;
          // Saturate at the top word so a full-depth load never wraps.
          if (!wptr_at_end) wptr_d = wptr_q + 1'b1;
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wptr_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
    end
  end

  // Storage is deliberately not reset; a reset mid-load keeps what was written.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wptr_q] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction <= '0;
      fetch_valid <= 1'b0;
    end else begin
      fetch_valid <= fetch_accept;
      if (fetch_accept) instruction <= rd_word[INST_W-1:0];
    end
  end

`ifdef PROG_MEM_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)             parity_err <= 1'b0;
    else if (fetch_accept) parity_err <= ^rd_word;
  end
`endif

`ifndef SYNTHESIS
  a_ready_excl: assert property (@(posedge clk) disable iff (reset)
    !(fetch_ready && load_ready));
  a_done_single: assert property (@(posedge clk) disable iff (reset)
    load_done |=> !load_done);
  a_no_fetch_in_load: assert property (@(posedge clk) disable iff (reset)
    load_ready |=> !fetch_valid);
`endif

endmodule

// File: tb/tb_program_mem.sv
// Scoreboarded random/directed bench for program_mem; a plain array models the memory.
module tb_program_mem;
  localparam int ADDR_W = 4;
  localparam int INST_W = 16;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset, fetch_req, load_start, load_valid, load_last;
  logic [ADDR_W-1:0] fetch_addr;
  logic [INST_W-1:0] load_data, instruction;
  logic              fetch_ready, fetch_valid, load_ready, load_done;
`ifdef PROG_MEM_PARITY_EN
  logic              parity_err;
`endif

  typedef struct {
    logic [INST_W-1:0] data;
    logic              perr;
  } exp_t;

  exp_t              exp_q[$];
  logic [INST_W-1:0] ref_mem [DEPTH];
  logic [INST_W-1:0] wq[$];
  int                errors = 0, checks = 0;
  int                done_seen = 0, done_exp = 0;

  program_mem #(.ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .instruction(instruction), .fetch_valid(fetch_valid),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
`ifdef PROG_MEM_PARITY_EN
    .load_done(load_done), .parity_err(parity_err)
`else
    .load_done(load_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (load_done === 1'b1) done_seen++;
      if (!reset && fetch_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch_valid: got instruction 0x%0h with no fetch outstanding", instruction);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("fetch_data", instruction, e.data);
`ifdef PROG_MEM_PARITY_EN
          chk("parity_err", parity_err, e.perr);
`endif
        end
      end
    end
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a, input logic perr);
    exp_t e;
    fetch_req  = 1'b1;
    fetch_addr = a;
    e.data = ref_mem[a];
    e.perr = perr;
    exp_q.push_back(e);
    step();
    fetch_req = 1'b0;
  endtask

  // Streams words into an already-started load, with random gaps and stray fetches.
  task automatic feed_words(input logic [INST_W-1:0] words[$], input bit use_last);
    int wp = 0;
    foreach (words[i]) begin
      if ($urandom_range(3) == 0) begin
        load_valid = 1'b0;
        fetch_req  = 1'($urandom_range(1));
        fetch_addr = ADDR_W'($urandom);
        step();
        chk("fetch_valid_in_load", fetch_valid, 0);
      end
      load_valid = 1'b1;
      load_data  = words[i];
      load_last  = use_last && (i == words.size() - 1);
      fetch_req  = 1'($urandom_range(1));
      fetch_addr = ADDR_W'($urandom);
      chk("fetch_ready_in_load", fetch_ready, 0);
      step();
      ref_mem[wp] = words[i];
      if (wp < DEPTH - 1) wp++;
      if (i < words.size() - 1) chk("fetch_valid_in_load", fetch_valid, 0);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    fetch_req  = 1'b0;
    done_exp++;
    chk("load_done_pulse", load_done, 1);
    chk("load_ready_done", load_ready, 0);
    chk("fetch_ready_done", fetch_ready, 0);
    step();
    chk("load_done_clear", load_done, 0);
    chk("fetch_ready_idle", fetch_ready, 1);
    chk("load_ready_idle", load_ready, 0);
  endtask

  task automatic do_load(input logic [INST_W-1:0] words[$], input bit use_last);
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("load_ready_in_load", load_ready, 1);
    chk("fetch_ready_in_load", fetch_ready, 0);
    feed_words(words, use_last);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_fetch_ready"}, fetch_ready, 1);
    chk({tag, "_load_ready"}, load_ready, 0);
    chk({tag, "_fetch_valid"}, fetch_valid, 0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_instruction"}, instruction, 0);
`ifdef PROG_MEM_PARITY_EN
    chk({tag, "_parity_err"}, parity_err, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; load_start = 1'b0;
    load_valid = 1'b0; load_data = '0; load_last = 1'b0;
    fork monitor(); join_none
    step(); step();
    check_reset_state("reset");
    reset = 1'b0;
    step();

    // Directed four-word load with load_last, then fetch each address.
    wq = {16'h1E07, 16'hFE00, 16'hBE01, 16'hCA00};
    do_load(wq, 1'b1);
    for (int a = 0; a < 4; a++) fetch(ADDR_W'(a), 1'b0);

    // Full-depth load with no load_last: must finish on the 16th word.
    wq = {};
    for (int i = 0; i < DEPTH; i++) wq.push_back(INST_W'(i));
    do_load(wq, 1'b0);
    fetch(4'd15, 1'b0);
    fetch(4'd0, 1'b0);

    // load_start and fetch_req together: load wins, fetch dropped.
    load_start = 1'b1; fetch_req = 1'b1; fetch_addr = 4'd3;
    step();
    load_start = 1'b0; fetch_req = 1'b0;
    chk("collide_load_ready", load_ready, 1);
    chk("collide_fetch_valid", fetch_valid, 0);
    wq = {16'hA5A5};
    feed_words(wq, 1'b1);
    fetch(4'd0, 1'b0);
    fetch(4'd1, 1'b0);

    // Reset after two of four load words: no done pulse, words kept.
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    load_valid = 1'b1; load_data = 16'h1234;
    step(); ref_mem[0] = 16'h1234;
    load_data = 16'h5678;
    step(); ref_mem[1] = 16'h5678;
    load_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_reset_state("midload_reset");
    fetch(4'd1, 1'b0);
    fetch(4'd0, 1'b0);
    fetch(4'd2, 1'b0);

    // Randomized loads of varying length interleaved with fetches.
    for (int it = 0; it < 8; it++) begin
      int n;
      bit ul;
      n = $urandom_range(DEPTH, 1);
      ul = (n < DEPTH) ? 1'b1 : 1'($urandom_range(1));
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(INST_W'($urandom));
      do_load(wq, ul);
      for (int f = 0; f < int'($urandom_range(8, 3)); f++) begin
        fetch(ADDR_W'($urandom), 1'b0);
        if ($urandom_range(2) == 0) step();
      end
    end

`ifdef PROG_MEM_PARITY_EN
    wq = {16'h0001};
    do_load(wq, 1'b1);
    dut.mem[0] = dut.mem[0] ^ 17'h00001;
    ref_mem[0] = 16'h0000;
    fetch(4'd0, 1'b1);
`endif

    step(); step(); step();
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("load_done_count", done_seen, done_exp);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
